// File: rtl/load_store_mem_access_stage_pkg.sv
// Shared encodings for the load/store memory-access stage:
// transfer sizes, write-enable bit positions and FSM states.
package load_store_mem_access_stage_pkg;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   localparam int WEN_RD = 0;
   localparam int WEN_RN = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/load_store_mem_access_stage_ld_data_align.sv
// Load data alignment: picks the addressed byte/halfword lane out of the
// read word and zero- or sign-extends it to 32 bits.
module ld_data_align
   import load_store_mem_access_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  ctrl_ld_mux,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[7:0];
      case (addr_lo)
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         2'd3:    byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      // Size 11 is not a legal encoding and falls through to word.
      ld_data = rdata;
      case (ctrl_ld_mux[1:0])
         SIZE_BYTE: ld_data = ctrl_ld_mux[2] ? {{24{byte_lane[7]}}, byte_lane}
                                             : {24'h000000, byte_lane};
         SIZE_HALF: ld_data = ctrl_ld_mux[2] ? {{16{half_lane[15]}}, half_lane}
                                             : {16'h0000, half_lane};
         default:   ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_mem_access_stage.sv
// Memory-access stage: runs one req/ack data-memory transaction per accepted
// load/store and emits a one-cycle Rd/Rn writeback packet on completion.
module load_store_mem_access_stage
   import load_store_mem_access_stage_pkg::*;
#(
   parameter int TAG_W  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              pipe_start_in,
   input  logic              instr_exec_confirmed_in,
   input  logic              ld_str_multiple_flag_in,
   input  logic [ADDR_W-1:0] addr_to_mem_in,
   input  logic [3:0]        rd_addr_in,
   input  logic [3:0]        rn_addr_in,
   input  logic [ADDR_W-1:0] rn_data_in,
   input  logic [ADDR_W-1:0] str_data_in,
   input  logic [2:0]        ctrl_ld_mux_in,
   input  logic [1:0]        ctrl_str_mux_in,
   input  logic [1:0]        w_en_in,
   input  logic [TAG_W-1:0]  instr_tag_in,
   output logic              stall_out,
   output logic              mem_req_out,
   output logic              mem_we_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [ADDR_W-1:0] mem_wdata_out,
   output logic [3:0]        mem_be_out,
   input  logic              mem_ack_in,
   input  logic [ADDR_W-1:0] mem_rdata_in,
   output logic              wb_valid_out,
   output logic              wb_rd_en_out,
   output logic              wb_rn_en_out,
   output logic [3:0]        wb_rd_addr_out,
   output logic [3:0]        wb_rn_addr_out,
   output logic [ADDR_W-1:0] wb_rd_data_out,
   output logic [ADDR_W-1:0] wb_rn_data_out,
   output logic [TAG_W-1:0]  wb_instr_tag_out
);

   state_t            state_q, state_d;
   logic              accept, launch, done;
   logic [ADDR_W-1:0] st_wdata;
   logic [3:0]        st_be;
   logic [ADDR_W-1:0] ld_data;

   logic [2:0]        ld_ctrl_q;
   logic [1:0]        addr_lo_q;
   logic [3:0]        rd_addr_q, rn_addr_q;
   logic [ADDR_W-1:0] rn_data_q;
   logic              rd_en_q, rn_en_q;
   logic [TAG_W-1:0]  tag_q;

   assign accept      = (state_q == ST_IDLE) & pipe_start_in;
   assign launch      = accept & instr_exec_confirmed_in;
   assign done        = (state_q == ST_BUSY) & mem_ack_in;
   assign stall_out   = (state_q == ST_BUSY);
   assign mem_req_out = (state_q == ST_BUSY);

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (launch) state_d = ST_BUSY;
         ST_BUSY: if (mem_ack_in) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Store data is replicated across every lane so the memory can take
   // whichever lanes the byte enables select.
   always_comb begin
      st_wdata = str_data_in;
      st_be    = 4'b1111;
      case (ctrl_str_mux_in)
         SIZE_BYTE: begin
            st_wdata = {4{str_data_in[7:0]}};
            st_be    = 4'b0001 << addr_to_mem_in[1:0];
         end
         SIZE_HALF: begin
            st_wdata = {2{str_data_in[15:0]}};
            st_be    = addr_to_mem_in[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_wdata = str_data_in;
            st_be    = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         mem_we_out    <= 1'b0;
         mem_addr_out  <= '0;
         mem_wdata_out <= '0;
         mem_be_out    <= 4'b0000;
         ld_ctrl_q     <= 3'b000;
         addr_lo_q     <= 2'b00;
         rd_addr_q     <= 4'h0;
         rn_addr_q     <= 4'h0;
         rn_data_q     <= '0;
         rd_en_q       <= 1'b0;
         rn_en_q       <= 1'b0;
         tag_q         <= '0;
      end else if (launch) begin
         mem_we_out    <= ~w_en_in[WEN_RD];
         mem_addr_out  <= {addr_to_mem_in[ADDR_W-1:2], 2'b00};
         mem_wdata_out <= st_wdata;
         mem_be_out    <= st_be;
         ld_ctrl_q     <= ctrl_ld_mux_in;
         addr_lo_q     <= addr_to_mem_in[1:0];
         rd_addr_q     <= rd_addr_in;
         rn_addr_q     <= rn_addr_in;
         rn_data_q     <= rn_data_in;
         rd_en_q       <= w_en_in[WEN_RD];
         rn_en_q       <= w_en_in[WEN_RN] & ~ld_str_multiple_flag_in;
         tag_q         <= instr_tag_in;
      end
   end

   ld_data_align u_ld_data_align (
      .rdata       (mem_rdata_in),
      .addr_lo     (addr_lo_q),
      .ctrl_ld_mux (ld_ctrl_q),
      .ld_data     (ld_data)
   );

   // Writeback packet: valid for exactly the cycle after the ack.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         wb_valid_out     <= 1'b0;
         wb_rd_en_out     <= 1'b0;
         wb_rn_en_out     <= 1'b0;
         wb_rd_addr_out   <= 4'h0;
         wb_rn_addr_out   <= 4'h0;
         wb_rd_data_out   <= '0;
         wb_rn_data_out   <= '0;
         wb_instr_tag_out <= '0;
      end else begin
         wb_valid_out <= done;
         if (done) begin
            wb_rd_en_out     <= rd_en_q;
            wb_rn_en_out     <= rn_en_q;
            wb_rd_addr_out   <= rd_addr_q;
            wb_rn_addr_out   <= rn_addr_q;
            wb_rd_data_out   <= ld_data;
            wb_rn_data_out   <= rn_data_q;
            wb_instr_tag_out <= tag_q;
         end
      end
   end

endmodule

// File: tb/tb_load_store_mem_access_stage.sv
// Directed self-checking bench for load_store_mem_access_stage: loads,
// stores, LDM beats, delayed ack, squash and reset during a transaction.
module tb_load_store_mem_access_stage;

   logic        clk;
   logic        rst_n;
   logic        pipe_start;
   logic        exec_ok;
   logic        ldm_flag;
   logic [31:0] addr;
   logic [3:0]  rd_addr;
   logic [3:0]  rn_addr;
   logic [31:0] rn_data;
   logic [31:0] str_data;
   logic [2:0]  ld_mux;
   logic [1:0]  str_mux;
   logic [1:0]  w_en;
   logic [3:0]  tag;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic        wb_rd_en;
   logic        wb_rn_en;
   logic [3:0]  wb_rd_addr;
   logic [3:0]  wb_rn_addr;
   logic [31:0] wb_rd_data;
   logic [31:0] wb_rn_data;
   logic [3:0]  wb_tag;

   int total = 0;
   int bad   = 0;

   load_store_mem_access_stage #(.TAG_W(4), .ADDR_W(32)) dut (
      .clk_in                  (clk),
      .reset_in                (rst_n),
      .pipe_start_in           (pipe_start),
      .instr_exec_confirmed_in (exec_ok),
      .ld_str_multiple_flag_in (ldm_flag),
      .addr_to_mem_in          (addr),
      .rd_addr_in              (rd_addr),
      .rn_addr_in              (rn_addr),
      .rn_data_in              (rn_data),
      .str_data_in             (str_data),
      .ctrl_ld_mux_in          (ld_mux),
      .ctrl_str_mux_in         (str_mux),
      .w_en_in                 (w_en),
      .instr_tag_in            (tag),
      .stall_out               (stall),
      .mem_req_out             (mem_req),
      .mem_we_out              (mem_we),
      .mem_addr_out            (mem_addr),
      .mem_wdata_out           (mem_wdata),
      .mem_be_out              (mem_be),
      .mem_ack_in              (mem_ack),
      .mem_rdata_in            (mem_rdata),
      .wb_valid_out            (wb_valid),
      .wb_rd_en_out            (wb_rd_en),
      .wb_rn_en_out            (wb_rn_en),
      .wb_rd_addr_out          (wb_rd_addr),
      .wb_rn_addr_out          (wb_rn_addr),
      .wb_rd_data_out          (wb_rd_data),
      .wb_rn_data_out          (wb_rn_data),
      .wb_instr_tag_out        (wb_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   // One complete operation, entered and left at posedge+1.
   task automatic applyStimulus(
      input string       name,
      input logic [31:0] a, input logic [3:0] rd, input logic [3:0] rn,
      input logic [31:0] rnd, input logic [31:0] sd,
      input logic [2:0]  lm, input logic [1:0] sm, input logic [1:0] we_bits,
      input logic        ldm, input logic [3:0] t, input logic [31:0] rdata,
      input int          delay,
      input logic [31:0] exp_addr, input logic exp_we,
      input logic [31:0] exp_wdata, input logic [3:0] exp_be,
      input logic        exp_rd_en, input logic exp_rn_en,
      input logic [31:0] exp_rd_data);
      addr = a; rd_addr = rd; rn_addr = rn; rn_data = rnd; str_data = sd;
      ld_mux = lm; str_mux = sm; w_en = we_bits; ldm_flag = ldm; tag = t;
      exec_ok = 1'b1; pipe_start = 1'b1;
      @(posedge clk); #1;
      pipe_start = 1'b0;
      checkOutput({name, ".stall"},    32'(stall), 32'd1);
      checkOutput({name, ".mem_req"},  32'(mem_req), 32'd1);
      checkOutput({name, ".mem_addr"}, mem_addr, exp_addr);
      checkOutput({name, ".mem_we"},   32'(mem_we), 32'(exp_we));
      if (exp_we) begin
         checkOutput({name, ".wdata"}, mem_wdata, exp_wdata);
         checkOutput({name, ".be"},    32'(mem_be), 32'(exp_be));
      end
      for (int i = 0; i < delay; i++) begin
         @(posedge clk); #1;
         checkOutput({name, ".req_hold"}, 32'(mem_req), 32'd1);
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      checkOutput({name, ".wb_valid"}, 32'(wb_valid), 32'd1);
      checkOutput({name, ".rd_en"},    32'(wb_rd_en), 32'(exp_rd_en));
      checkOutput({name, ".rn_en"},    32'(wb_rn_en), 32'(exp_rn_en));
      checkOutput({name, ".tag"},      32'(wb_tag), 32'(t));
      checkOutput({name, ".stall_end"}, 32'(stall), 32'd0);
      if (exp_rd_en) begin
         checkOutput({name, ".rd_addr"}, 32'(wb_rd_addr), 32'(rd));
         checkOutput({name, ".rd_data"}, wb_rd_data, exp_rd_data);
      end
      if (exp_rn_en) begin
         checkOutput({name, ".rn_addr"}, 32'(wb_rn_addr), 32'(rn));
         checkOutput({name, ".rn_data"}, wb_rn_data, rnd);
      end
      @(posedge clk); #1;
      checkOutput({name, ".wb_pulse"}, 32'(wb_valid), 32'd0);
   endtask

   initial begin
      int stall_cnt;
      int wb_cnt;
      rst_n = 1'b0; pipe_start = 1'b0; exec_ok = 1'b0; ldm_flag = 1'b0;
      addr = '0; rd_addr = '0; rn_addr = '0; rn_data = '0; str_data = '0;
      ld_mux = '0; str_mux = '0; w_en = '0; tag = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      #3;
      checkOutput("rst.stall",    32'(stall), 32'd0);
      checkOutput("rst.mem_req",  32'(mem_req), 32'd0);
      checkOutput("rst.wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("rst.mem_addr", mem_addr, 32'd0);
      checkOutput("rst.rd_data",  wb_rd_data, 32'd0);
      #14 rst_n = 1'b1;
      @(posedge clk); #1;

      applyStimulus("ldr", 32'h0000_1004, 4'd3, 4'd5, 32'h0, 32'h0, 3'b000, 2'b00, 2'b01,
                    1'b0, 4'h1, 32'hDEAD_BEEF, 0,
                    32'h0000_1004, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
      applyStimulus("ldrsb", 32'h0000_2003, 4'd4, 4'd0, 32'h0, 32'h0, 3'b110, 2'b00, 2'b01,
                    1'b0, 4'h2, 32'h8011_2233, 0,
                    32'h0000_2000, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'hFFFF_FF80);
      applyStimulus("ldrh", 32'h0000_2002, 4'd6, 4'd0, 32'h0, 32'h0, 3'b001, 2'b00, 2'b01,
                    1'b0, 4'h3, 32'h8011_2233, 1,
                    32'h0000_2000, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_8011);
      applyStimulus("ldrsh", 32'h0000_2003, 4'd7, 4'd0, 32'h0, 32'h0, 3'b101, 2'b00, 2'b01,
                    1'b0, 4'h4, 32'h8011_2233, 0,
                    32'h0000_2000, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'hFFFF_8011);
      applyStimulus("ldrb_lo", 32'h0000_2001, 4'd8, 4'd0, 32'h0, 32'h0, 3'b010, 2'b00, 2'b01,
                    1'b0, 4'h5, 32'h8011_22C3, 0,
                    32'h0000_2000, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_0022);
      applyStimulus("strb", 32'h0000_3001, 4'd1, 4'd2, 32'h0, 32'h0000_00A5, 3'b000, 2'b10, 2'b00,
                    1'b0, 4'h6, 32'h0, 0,
                    32'h0000_3000, 1'b1, 32'hA5A5_A5A5, 4'b0010, 1'b0, 1'b0, 32'h0);
      applyStimulus("strh_wb", 32'h0000_3002, 4'd1, 4'd9, 32'h0000_3006, 32'h1234_BEEF, 3'b000,
                    2'b01, 2'b10, 1'b0, 4'h7, 32'h0, 2,
                    32'h0000_3000, 1'b1, 32'hBEEF_BEEF, 4'b1100, 1'b0, 1'b1, 32'h0);
      applyStimulus("str_word", 32'h0000_4008, 4'd1, 4'd2, 32'h0, 32'h0BAD_F00D, 3'b000, 2'b00,
                    2'b00, 1'b0, 4'h8, 32'h0, 0,
                    32'h0000_4008, 1'b1, 32'h0BAD_F00D, 4'b1111, 1'b0, 1'b0, 32'h0);
      applyStimulus("ldm_beat", 32'h0000_5000, 4'd10, 4'd11, 32'h0000_5010, 32'h0, 3'b000, 2'b00,
                    2'b11, 1'b1, 4'h9, 32'h1357_9BDF, 0,
                    32'h0000_5000, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h1357_9BDF);

      // Ack arrives in the sixth busy cycle while upstream keeps requesting.
      addr = 32'h0000_6004; rd_addr = 4'd12; w_en = 2'b01; ld_mux = 3'b000; ldm_flag = 1'b0;
      tag = 4'hA; exec_ok = 1'b1; pipe_start = 1'b1;
      stall_cnt = 0; wb_cnt = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         if (stall) stall_cnt++;
         checkOutput("hold.req",  32'(mem_req), 32'd1);
         checkOutput("hold.addr", mem_addr, 32'h0000_6004);
         if (i == 5) begin
            mem_ack = 1'b1; mem_rdata = 32'h0000_0042;
         end
         @(posedge clk); #1;
         if (wb_valid) wb_cnt++;
      end
      pipe_start = 1'b0; mem_ack = 1'b0;
      checkOutput("hold.stall_cycles", 32'(stall_cnt), 32'd6);
      checkOutput("hold.rd_data", wb_rd_data, 32'h0000_0042);
      checkOutput("hold.no_reaccept", 32'(stall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (wb_valid) wb_cnt++;
         checkOutput("hold.idle_req", 32'(mem_req), 32'd0);
      end
      checkOutput("hold.wb_count", 32'(wb_cnt), 32'd1);

      // Squashed operation.
      addr = 32'h0000_7000; exec_ok = 1'b0; pipe_start = 1'b1;
      @(posedge clk); #1;
      pipe_start = 1'b0;
      checkOutput("squash.stall",   32'(stall), 32'd0);
      checkOutput("squash.mem_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      checkOutput("squash.wb_valid", 32'(wb_valid), 32'd0);

      // Reset asserted while a transaction is outstanding, then a late ack.
      addr = 32'h0000_8000; rd_addr = 4'd13; w_en = 2'b01; exec_ok = 1'b1; pipe_start = 1'b1;
      @(posedge clk); #1;
      pipe_start = 1'b0;
      checkOutput("rstbusy.req_before", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rstbusy.req_drop",   32'(mem_req), 32'd0);
      checkOutput("rstbusy.stall_drop", 32'(stall), 32'd0);
      #2 rst_n = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      checkOutput("rstbusy.late_ack_wb", 32'(wb_valid), 32'd0);
      checkOutput("rstbusy.late_ack_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      checkOutput("rstbusy.late_ack_wb2", 32'(wb_valid), 32'd0);
      applyStimulus("after_rst", 32'h0000_9008, 4'd14, 4'd0, 32'h0, 32'h0, 3'b000, 2'b00, 2'b01,
                    1'b0, 4'hB, 32'hCAFE_0001, 1,
                    32'h0000_9008, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'hCAFE_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
